// File: rtl/spin_delta_e_pipe.sv
// Two-stage pipelined spin-flip energy change: dE = s_c * (sum_k J_k*s_k + H),
// saturated to DE_W, with valid/ready on both sides and a completed-result counter.
module spin_delta_e_pipe #(
    parameter int N_NEIGH = 4,
    parameter int J_W     = 4,
    parameter int H_W     = 8,
    parameter int DE_W    = 12,
    parameter int TAG_W   = 10,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     spin_val,
    input  logic [N_NEIGH-1:0]       neigh,
    input  logic [N_NEIGH*J_W-1:0]   j_vec,
    input  logic [H_W-1:0]           h_field,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DE_W-1:0]          dE,
    output logic                     sat,
    output logic [TAG_W-1:0]         tag_out,
    output logic [CNT_W-1:0]         done_count
);

    // Largest possible magnitude of the neighbour sum plus field; two spare bits
    // keep both the sum and its negation exact.
    localparam int MAG   = N_NEIGH * (2 ** (J_W - 1)) + 2 ** (H_W - 1);
    localparam int SUM_W = $clog2(MAG) + 2;
    localparam int EXT_W = ((SUM_W > DE_W) ? SUM_W : DE_W) + 1;
    localparam logic signed [EXT_W-1:0] DE_MAX = EXT_W'((64'sd1 <<< (DE_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] DE_MIN = ~DE_MAX;

    logic                    s1_valid_r;
    logic signed [SUM_W-1:0] s1_sum_r;
    logic                    s1_spin_r;
    logic [TAG_W-1:0]        s1_tag_r;

    logic                    load2_s;
    logic                    load1_s;
    logic                    in_fire_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] term_s;
    logic [J_W-1:0]          jk_s;
    logic signed [EXT_W-1:0] sum_ext_s;
    logic signed [EXT_W-1:0] res_s;
    logic [DE_W-1:0]         de_s;
    logic                    sat_s;

    assign load2_s   = !out_valid || out_ready;
    assign load1_s   = !s1_valid_r || load2_s;
    assign in_ready  = !rst && load1_s;
    assign in_fire_s = in_valid && in_ready;

    // Signed neighbour sum plus external field at full internal width.
    always_comb begin
        sum_s  = {{(SUM_W-H_W){h_field[H_W-1]}}, h_field};
        jk_s   = '0;
        term_s = '0;
        for (int k = 0; k < N_NEIGH; k++) begin
            jk_s   = j_vec[k*J_W +: J_W];
            term_s = {{(SUM_W-J_W){jk_s[J_W-1]}}, jk_s};
            if (neigh[k]) begin
                sum_s = sum_s + term_s;
            end else begin
                sum_s = sum_s - term_s;
            end
        end
    end

    // Centre-spin sign application and clipping to the output width.
    always_comb begin
        sum_ext_s = {{(EXT_W-SUM_W){s1_sum_r[SUM_W-1]}}, s1_sum_r};
        if (s1_spin_r) begin
            res_s = sum_ext_s;
        end else begin
            res_s = -sum_ext_s;
        end
        if (res_s > DE_MAX) begin
            de_s  = DE_MAX[DE_W-1:0];
            sat_s = 1'b1;
        end else if (res_s < DE_MIN) begin
            de_s  = DE_MIN[DE_W-1:0];
            sat_s = 1'b1;
        end else begin
            de_s  = res_s[DE_W-1:0];
            sat_s = 1'b0;
        end
    end

    // Stage 1: capture sum, centre spin and tag on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= '0;
            s1_spin_r  <= 1'b0;
            s1_tag_r   <= '0;
        end else if (load1_s) begin
            s1_valid_r <= in_fire_s;
            if (in_fire_s) begin
                s1_sum_r  <= sum_s;
                s1_spin_r <= spin_val;
                s1_tag_r  <= tag_in;
            end
        end
    end

    // Stage 2: output registers, frozen while the result is stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dE        <= '0;
            sat       <= 1'b0;
            tag_out   <= '0;
        end else if (load2_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                dE      <= de_s;
                sat     <= sat_s;
                tag_out <= s1_tag_r;
            end
        end
    end

    // Completed output transfers, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_count <= '0;
        end else if (out_valid && out_ready) begin
            done_count <= done_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_spin_delta_e_pipe.sv
// Directed bench: a default instance and a narrow one (DE_W=6, CNT_W=4) share one input stream.
module tb_spin_delta_e_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        spin_val;
    logic [3:0]  neigh;
    logic [15:0] j_vec;
    logic [7:0]  h_field;
    logic [9:0]  tag_in;
    logic        out_ready;

    logic               d_in_ready, d_out_valid, d_sat;
    logic signed [11:0] d_de;
    logic [9:0]         d_tag;
    logic [15:0]        d_cnt;

    logic               s_in_ready, s_out_valid, s_sat;
    logic signed [5:0]  s_de;
    logic [9:0]         s_tag;
    logic [3:0]         s_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spin_delta_e_pipe u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .spin_val(spin_val), .neigh(neigh), .j_vec(j_vec), .h_field(h_field),
        .tag_in(tag_in), .out_valid(d_out_valid), .out_ready(out_ready),
        .dE(d_de), .sat(d_sat), .tag_out(d_tag), .done_count(d_cnt)
    );

    spin_delta_e_pipe #(.DE_W(6), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .spin_val(spin_val), .neigh(neigh), .j_vec(j_vec), .h_field(h_field),
        .tag_in(tag_in), .out_valid(s_out_valid), .out_ready(out_ready),
        .dE(s_de), .sat(s_sat), .tag_out(s_tag), .done_count(s_cnt)
    );

    // Legacy 4-neighbour table: dE = s_c * (2*popcount(neigh) - 4).
    function automatic logic signed [11:0] legacy_de(input logic [4:0] v);
        int pc;
        int s;
        pc = 0;
        for (int b = 0; b < 4; b++) pc += int'(v[b]);
        s = 2 * pc - 4;
        return v[4] ? 12'(s) : 12'(-s);
    endfunction

    // One isolated transfer; inputs are scrambled right after acceptance.
    task automatic xfer(input logic sp, input logic [3:0] nb, input logic [15:0] j,
                        input logic [7:0] h, input logic [9:0] tg);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; spin_val = sp; neigh = nb;
        j_vec = j; h_field = h; tag_in = tg;
        @(negedge clk);
        in_valid = 1'b0; spin_val = ~sp; neigh = ~nb; j_vec = ~j; h_field = ~h; tag_in = ~tg;
        for (int c = 0; c < 4 && !d_out_valid; c++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; spin_val = 1'b0;
        neigh = 4'h0; j_vec = 16'h1111; h_field = 8'h00; tag_in = 10'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({d_in_ready, d_out_valid, d_sat, d_de, d_tag, d_cnt} !== {1'b0, 1'b0, 1'b0, 12'd0, 10'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b sat=%b dE=%0d tag=%0d cnt=%0d, want all 0",
                     d_in_ready, d_out_valid, d_sat, d_de, d_tag, d_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_in_ready, d_out_valid, s_in_ready, s_out_valid} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_release: d_rdy=%b d_vld=%b s_rdy=%b s_vld=%b, want rdy=1 vld=0",
                     d_in_ready, d_out_valid, s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_legacy_sweep;
        int rx;
        logic [4:0] v;
        logic signed [11:0] e;
        rx = 0;
        out_ready = 1'b1; j_vec = 16'h1111; h_field = 8'h00;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (d_out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL legacy_latency1: out_valid=%b one cycle after transfer, want 0", d_out_valid);
                end
            end
            if (i == 2) begin
                checks++;
                if ({d_out_valid, d_tag} !== {1'b1, 10'd0}) begin
                    failures++;
                    $display("FAIL legacy_latency2: out_valid=%b tag=%0d, want 1 and 0", d_out_valid, d_tag);
                end
            end
            if (d_out_valid) begin
                v = 5'(rx);
                e = legacy_de(v);
                checks++;
                if ({d_de, d_sat, d_tag, s_de, s_sat} !== {e, 1'b0, 10'(rx), e[5:0], 1'b0}) begin
                    failures++;
                    $display("FAIL legacy_%b: dE=%0d sat=%b tag=%0d small_dE=%0d small_sat=%b, want dE=%0d sat=0 tag=%0d",
                             v, d_de, d_sat, d_tag, s_de, s_sat, e, rx);
                end
                rx++;
            end
            in_valid = (i < 32);
            spin_val = i[4]; neigh = i[3:0]; tag_in = 10'(i);
        end
        checks++;
        if (rx !== 32 || d_cnt !== 16'd32 || s_cnt !== 4'd0) begin
            failures++;
            $display("FAIL legacy_count: seen=%0d done=%0d small_done=%0d, want 32 32 0", rx, d_cnt, s_cnt);
        end
    endtask

    task automatic test_field_coupling;
        xfer(1'b1, 4'hF, 16'h1111, 8'h03, 10'd1);
        checks++;
        if ({d_out_valid, d_sat, d_de, d_tag} !== {1'b1, 1'b0, 12'sd7, 10'd1}) begin
            failures++;
            $display("FAIL field_pos: vld=%b sat=%b dE=%0d tag=%0d, want 1 0 7 1", d_out_valid, d_sat, d_de, d_tag);
        end
        xfer(1'b0, 4'hF, 16'h1111, 8'h03, 10'd2);
        checks++;
        if ({d_out_valid, d_sat, d_de, d_tag} !== {1'b1, 1'b0, -12'sd7, 10'd2}) begin
            failures++;
            $display("FAIL field_neg: vld=%b sat=%b dE=%0d tag=%0d, want 1 0 -7 2", d_out_valid, d_sat, d_de, d_tag);
        end
        xfer(1'b1, 4'hA, 16'h7823, 8'hFB, 10'd3);
        checks++;
        if ({d_out_valid, d_sat, d_de, d_tag} !== {1'b1, 1'b0, 12'sd9, 10'd3}) begin
            failures++;
            $display("FAIL coupling_mix: vld=%b sat=%b dE=%0d tag=%0d, want 1 0 9 3", d_out_valid, d_sat, d_de, d_tag);
        end
    endtask

    task automatic test_saturation;
        xfer(1'b1, 4'hF, 16'h7777, 8'h7F, 10'd4);
        checks++;
        if ({s_out_valid, s_sat, s_de, d_sat, d_de} !== {1'b1, 1'b1, 6'h1F, 1'b0, 12'sd155}) begin
            failures++;
            $display("FAIL sat_pos: small vld=%b sat=%b dE=%0d, wide sat=%b dE=%0d, want 1 1 31, 0 155",
                     s_out_valid, s_sat, s_de, d_sat, d_de);
        end
        xfer(1'b0, 4'hF, 16'h7777, 8'h7F, 10'd5);
        checks++;
        if ({s_out_valid, s_sat, s_de, d_sat, d_de} !== {1'b1, 1'b1, 6'h20, 1'b0, -12'sd155}) begin
            failures++;
            $display("FAIL sat_neg: small vld=%b sat=%b dE=%0d, wide sat=%b dE=%0d, want 1 1 -32, 0 -155",
                     s_out_valid, s_sat, s_de, d_sat, d_de);
        end
        xfer(1'b1, 4'hF, 16'h7777, 8'h03, 10'd6);
        checks++;
        if ({s_sat, s_de} !== {1'b0, 6'h1F}) begin
            failures++;
            $display("FAIL sat_edge_max: sat=%b dE=%0d, want 0 31", s_sat, s_de);
        end
        xfer(1'b0, 4'hF, 16'h7777, 8'h04, 10'd7);
        checks++;
        if ({s_sat, s_de} !== {1'b0, 6'h20}) begin
            failures++;
            $display("FAIL sat_edge_min: sat=%b dE=%0d, want 0 -32", s_sat, s_de);
        end
        xfer(1'b1, 4'hF, 16'h7777, 8'h04, 10'd8);
        checks++;
        if ({s_sat, s_de} !== {1'b1, 6'h1F}) begin
            failures++;
            $display("FAIL sat_edge_over: sat=%b dE=%0d, want 1 31", s_sat, s_de);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int acc;
        int tag_next;
        int expt;
        acc = 0; tag_next = 1; expt = 1;
        out_ready = 1'b0; j_vec = 16'h1111; h_field = 8'h00; spin_val = 1'b1; neigh = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_out_valid) begin
                checks++;
                if (d_tag !== 10'd1) begin
                    failures++;
                    $display("FAIL bp_hold: tag=%0d while stalled, want 1", d_tag);
                end
            end
            in_valid = 1'b1; tag_in = 10'(tag_next);
            #1;
            if (d_in_ready) begin
                acc++;
                tag_next++;
            end
        end
        @(negedge clk);
        checks++;
        if (acc !== 2 || d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_tag !== 10'd1) begin
            failures++;
            $display("FAIL bp_full: accepted=%0d rdy=%b vld=%b tag=%0d, want 2 0 1 1",
                     acc, d_in_ready, d_out_valid, d_tag);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && expt < 6; c++) begin
            in_valid = (tag_next <= 5); tag_in = 10'(tag_next);
            #1;
            if (d_out_valid) begin
                checks++;
                if (d_tag !== 10'(expt)) begin
                    failures++;
                    $display("FAIL bp_order: tag=%0d, want %0d", d_tag, expt);
                end
                expt++;
            end
            if (in_valid && d_in_ready) tag_next++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (expt !== 6) begin
            failures++;
            $display("FAIL bp_drain: next expected tag=%0d after release, want 6", expt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; tag_in = 10'd100;
        @(negedge clk);
        tag_in = 10'd101;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({d_out_valid, d_tag, d_in_ready} !== {1'b1, 10'd100, 1'b0}) begin
            failures++;
            $display("FAIL rmid_inflight: vld=%b tag=%0d rdy=%b, want 1 100 0", d_out_valid, d_tag, d_in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({d_out_valid, d_cnt, d_in_ready} !== {1'b0, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL rmid_after: vld=%b cnt=%0d rdy=%b, want 0 0 1", d_out_valid, d_cnt, d_in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (d_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rmid_stale: vld=%b small_vld=%b tag=%0d, want no result", d_out_valid, s_out_valid, d_tag);
            end
        end
    endtask

    task automatic test_counter_wrap;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; tag_in = 10'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (s_cnt !== 4'd1 || d_cnt !== 16'd17) begin
            failures++;
            $display("FAIL cnt_wrap: small_done=%0d wide_done=%0d, want 1 17", s_cnt, d_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_legacy_sweep();
        test_field_coupling();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
